// File: rtl/conn_pkg.sv
// Shared types and sizing helpers for the TOE connection manager.
package conn_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PEND  = 3'd1,
        WAIT  = 3'd2,
        UP    = 3'd3,
        CPEND = 3'd4,
        CWAIT = 3'd5
    } sess_state_t;

    localparam logic REQ_CONNECT = 1'b0;
    localparam logic REQ_CLOSE   = 1'b1;

    // Timer only needs to count up to TIMEOUT-1.
    function automatic int tmr_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

    // Retry counter holds 0..MAX_RETRY.
    function automatic int rty_width(input int max_retry);
        return (max_retry > 0) ? $clog2(max_retry + 1) : 1;
    endfunction

endpackage

// File: rtl/conn_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the pointer, pointer
// moves past the winner only when the grant is actually taken.
module conn_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         load,
    output logic [N-1:0] gnt,
    output logic         gnt_vld
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] k;

    // Scan from the pointer and take the first requester found
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        k       = '0;
        for (int i = 0; i < N; i++) begin
            k = IDX_W'((int'(ptr) + i) % N);
            if (!gnt_vld && req[k]) begin
                gnt_vld = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = k;
            end
        end
    end

    // Advance the pointer to the session after the one just loaded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (load && gnt_vld) begin
            ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/conn_mgr_toe.sv
// Multi-session connection manager: per-session connect/disconnect FSMs,
// round-robin onto one TOE request channel, status tracking with timeout
// and bounded retries.
`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 32
`endif

module conn_mgr_toe
    import conn_pkg::*;
#(
    parameter int HOST_ADDR = `HOST_ADDR_WIDTH,
    parameter int NUM_SESS  = 4,
    parameter int SID_W     = $clog2(NUM_SESS),
    parameter int TIMEOUT   = 1024,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 api_connect_i,
    input  logic                 api_disconnect_i,
    input  logic [SID_W-1:0]     api_sess_i,
    input  logic [HOST_ADDR-1:0] api_addr_i,
    output logic                 api_ack_o,
    output logic                 api_nack_o,
    output logic                 toe_req_valid_o,
    input  logic                 toe_req_ready_i,
    output logic                 toe_req_close_o,
    output logic [SID_W-1:0]     toe_req_sess_o,
    output logic [HOST_ADDR-1:0] toe_req_addr_o,
    input  logic                 toe_sts_valid_i,
    input  logic [SID_W-1:0]     toe_sts_sess_i,
    input  logic                 toe_sts_ok_i,
    output logic [NUM_SESS-1:0]  sess_up_o,
    output logic [NUM_SESS-1:0]  evt_up_o,
    output logic [NUM_SESS-1:0]  evt_fail_o,
    output logic [NUM_SESS-1:0]  evt_closed_o
);

    localparam int TMR_W = tmr_width(TIMEOUT);
    localparam int RTY_W = rty_width(MAX_RETRY);

    wire [NUM_SESS-1:0]                arb_req, acc, rej, close_w;
    wire [NUM_SESS-1:0]                up_w, eup_w, efail_w, ecls_w;
    wire [NUM_SESS-1:0][HOST_ADDR-1:0] addr_w;

    logic [NUM_SESS-1:0]  gnt;
    logic                 gnt_vld, load, xfer, api_any;
    logic [SID_W-1:0]     sel_sess;
    logic [HOST_ADDR-1:0] sel_addr;
    logic                 sel_close;

    assign xfer    = toe_req_valid_o & toe_req_ready_i;
    assign load    = gnt_vld & (~toe_req_valid_o | toe_req_ready_i);
    assign api_any = api_connect_i | api_disconnect_i;

    assign sess_up_o    = up_w;
    assign evt_up_o     = eup_w;
    assign evt_fail_o   = efail_w;
    assign evt_closed_o = ecls_w;

    for (genvar s = 0; s < NUM_SESS; s++) begin : g_sess
        sess_state_t          st_q, st_n;
        logic [HOST_ADDR-1:0] addr_q, addr_n;
        logic [TMR_W-1:0]     tmr_q, tmr_n;
        logic [RTY_W-1:0]     rty_q, rty_n;
        logic                 up_q, up_n, eup_q, eup_n, efail_q, efail_n, ecls_q, ecls_n;
        logic                 acc_n, rej_n, sts_hit, api_hit, inflight, xfer_hit, tmo;

        assign sts_hit  = toe_sts_valid_i && (toe_sts_sess_i == SID_W'(s));
        assign api_hit  = api_any && (api_sess_i == SID_W'(s));
        assign inflight = toe_req_valid_o && (toe_req_sess_o == SID_W'(s));
        assign xfer_hit = xfer && inflight;
        assign tmo      = (tmr_q == TMR_W'(TIMEOUT - 1));

        // Next state: transfer/status/timeout first, then judge the API request on the result
        always_comb begin
            st_n    = st_q;
            addr_n  = addr_q;
            tmr_n   = tmr_q;
            rty_n   = rty_q;
            up_n    = up_q;
            eup_n   = 1'b0;
            efail_n = 1'b0;
            ecls_n  = 1'b0;
            acc_n   = 1'b0;
            rej_n   = 1'b0;
            case (st_q)
                PEND:  if (xfer_hit) begin st_n = WAIT;  tmr_n = '0; end
                CPEND: if (xfer_hit) begin st_n = CWAIT; tmr_n = '0; end
                WAIT: begin
                    if (sts_hit && toe_sts_ok_i) begin
                        st_n  = UP;
                        up_n  = 1'b1;
                        eup_n = 1'b1;
                    end else if (sts_hit || tmo) begin
                        if (rty_q < RTY_W'(MAX_RETRY)) begin
                            rty_n = rty_q + 1'b1;
                            st_n  = PEND;
                        end else begin
                            st_n    = IDLE;
                            efail_n = 1'b1;
                        end
                    end else begin
                        tmr_n = tmr_q + 1'b1;
                    end
                end
                CWAIT: begin
                    if (sts_hit || tmo) begin
                        st_n   = IDLE;
                        up_n   = 1'b0;
                        ecls_n = 1'b1;
                    end else begin
                        tmr_n = tmr_q + 1'b1;
                    end
                end
                default: ;
            endcase
            if (api_hit) begin
                if (api_connect_i) begin
                    if (st_n == IDLE) begin
                        acc_n  = 1'b1;
                        st_n   = PEND;
                        addr_n = api_addr_i;
                        rty_n  = '0;
                    end else begin
                        rej_n = 1'b1;
                    end
                end else begin
                    case (st_n)
                        UP, WAIT: begin acc_n = 1'b1; st_n = CPEND; end
                        PEND:     begin acc_n = 1'b1; st_n = IDLE; ecls_n = 1'b1; end
                        default:  rej_n = 1'b1;
                    endcase
                end
            end
        end

        // Session state and its registered status/event outputs
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                st_q    <= IDLE;
                addr_q  <= '0;
                tmr_q   <= '0;
                rty_q   <= '0;
                up_q    <= 1'b0;
                eup_q   <= 1'b0;
                efail_q <= 1'b0;
                ecls_q  <= 1'b0;
            end else begin
                st_q    <= st_n;
                addr_q  <= addr_n;
                tmr_q   <= tmr_n;
                rty_q   <= rty_n;
                up_q    <= up_n;
                eup_q   <= eup_n;
                efail_q <= efail_n;
                ecls_q  <= ecls_n;
            end
        end

        // A session already sitting in the request register is not offered again
        assign arb_req[s] = ((st_q == PEND) || (st_q == CPEND)) && !inflight;
        assign close_w[s] = (st_q == CPEND) ? REQ_CLOSE : REQ_CONNECT;
        assign addr_w[s]  = addr_q;
        assign acc[s]     = acc_n;
        assign rej[s]     = rej_n;
        assign up_w[s]    = up_q;
        assign eup_w[s]   = eup_q;
        assign efail_w[s] = efail_q;
        assign ecls_w[s]  = ecls_q;
    end

    conn_rr_arbiter #(.N(NUM_SESS), .IDX_W(SID_W)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .load    (load),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    // Mux the granted session's request fields
    always_comb begin
        sel_sess  = '0;
        sel_addr  = '0;
        sel_close = REQ_CONNECT;
        for (int i = 0; i < NUM_SESS; i++) begin
            if (gnt[i]) begin
                sel_sess  = SID_W'(i);
                sel_addr  = addr_w[i];
                sel_close = close_w[i];
            end
        end
    end

    // API response pulses and the held-while-stalled TOE request register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            api_ack_o       <= 1'b0;
            api_nack_o      <= 1'b0;
            toe_req_valid_o <= 1'b0;
            toe_req_close_o <= 1'b0;
            toe_req_sess_o  <= '0;
            toe_req_addr_o  <= '0;
        end else begin
            api_ack_o  <= |acc;
            // An out-of-range session index is rejected too
            api_nack_o <= (|rej) | (api_any & ~|(acc | rej));
            if (load) begin
                toe_req_valid_o <= 1'b1;
                toe_req_close_o <= sel_close;
                toe_req_sess_o  <= sel_sess;
                toe_req_addr_o  <= sel_addr;
            end else if (xfer) begin
                toe_req_valid_o <= 1'b0;
            end
        end
    end

endmodule
